// File: rtl/cpu_cs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_cs_pkg
//   Shared definitions for the writable control store readback slice:
//   section/address geometry, the readback sequencer state type and the
//   sizing rule for the access-cycle counter.
// -----------------------------------------------------------------------------
package cpu_cs_pkg;

    localparam int CS_SEC_W   = 16;  // width of one control-store section
    localparam int CS_NSEC    = 4;   // sections per microword
    localparam int CS_SEL_W   = 2;   // section index width
    localparam int CS_ADDR_W  = 12;  // control-store address width
    localparam int CS_ACC_CYC = 2;   // default enable-to-sample cycles

    // Counter wide enough to hold 0..accCyc.
    function automatic int accCntW(input int accCyc);
        return $clog2(accCyc + 1);
    endfunction

    localparam int CS_ACC_CNT_W = $clog2(CS_ACC_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        PRESENT = 2'd3
    } cs_rb_state_t;

endpackage

// File: rtl/cpu_cs_readback_sec_dec.sv
// -----------------------------------------------------------------------------
// cs_rb_sec_dec
//   2-to-4 active-low decoder with enable (74139 equivalent). Drives the
//   control-store section read enables: at most one output low, all high
//   while disabled.
// Ports
//   en   in  1  decoder enable (active high)
//   sel  in  2  section index
//   yN   out 4  active-low decoded outputs
// -----------------------------------------------------------------------------
module cs_rb_sec_dec
    import cpu_cs_pkg::*;
(
    input  logic                en,
    input  logic [CS_SEL_W-1:0] sel,
    output logic [CS_NSEC-1:0]  yN
);

    always_comb begin
        yN = '1;
        if (en) begin
            yN[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_cs_readback.sv
// -----------------------------------------------------------------------------
// cpu_cs_readback
//   Read-side sequencer for the writable control store. Fetches a microword
//   section by section (one active-low read enable at a time) and returns each
//   section over a valid/ready handshake for microcode verify and debug dump.
//
//   Sequence: IDLE -> SETUP (address setup, enables high) -> ACCESS (enable
//   low for ACC_CYC cycles, data sampled on the last one) -> PRESENT (hold
//   until accepted) -> SETUP for the next burst section, or IDLE.
//
// Ports
//   sysclk      in   1       system clock
//   sys_rst_n   in   1       asynchronous active-low reset
//   rd_req      in   1       start a readback (sampled in IDLE only)
//   rd_burst    in   1       1: all sections 0..3; 0: only rd_sel
//   rd_sel      in   2       section index for single reads
//   rd_addr     in   ADDR_W  microword address, captured with rd_req
//   busy        out  1       sequencer not idle
//   cs_addr     out  ADDR_W  registered control-store address
//   ER_n        out  NSEC    active-low section read enables
//   cs_data     in   SEC_W   control-store section data
//   dout        out  SEC_W   returned section
//   dout_sec    out  2       index of the section in dout
//   dout_valid  out  1       dout valid, held until dout_ready
//   dout_ready  in   1       consumer accepts dout
//   dout_last   out  1       final section of this request
//   cs_par      in   1       section parity bit     (CS_RB_PARITY_EN only)
//   par_err     out  1       sticky parity error    (CS_RB_PARITY_EN only)
//
// Build option
//   CS_RB_PARITY_EN : adds odd-parity checking of each sampled section.
// -----------------------------------------------------------------------------
module cpu_cs_readback
    import cpu_cs_pkg::*;
#(
    parameter int SEC_W   = CS_SEC_W,
    parameter int NSEC    = CS_NSEC,
    parameter int ADDR_W  = CS_ADDR_W,
    parameter int ACC_CYC = CS_ACC_CYC
)(
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic              rd_req,
    input  logic              rd_burst,
    input  logic [1:0]        rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] cs_addr,
    output logic [NSEC-1:0]   ER_n,
    input  logic [SEC_W-1:0]  cs_data,
    output logic [SEC_W-1:0]  dout,
    output logic [1:0]        dout_sec,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
`ifdef CS_RB_PARITY_EN
    ,
    input  logic              cs_par,
    output logic              par_err
`endif
);

    localparam int CNT_W = accCntW(ACC_CYC);

    cs_rb_state_t     state;
    cs_rb_state_t     stateNext;
    logic [1:0]       sec;
    logic             burstMode;
    logic [CNT_W-1:0] accCnt;

    logic accept;
    logic accLast;
    logic xfer;
    logic isLast;

    assign accept  = (state == IDLE) && rd_req;
    assign accLast = (state == ACCESS) && (accCnt == CNT_W'(ACC_CYC - 1));
    assign xfer    = (state == PRESENT) && dout_valid && dout_ready;
    assign isLast  = !burstMode || (sec == 2'd3);

    // Combinational from state so reset forces busy low without a clock.
    assign busy = (state != IDLE);

    // Enables are decoded straight from state: an async reset parks the
    // state in IDLE and the enables release immediately.
    cs_rb_sec_dec uSecDec (
        .en  (state == ACCESS),
        .sel (sec),
        .yN  (ER_n)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (rd_req)  stateNext = SETUP;
            SETUP:                stateNext = ACCESS;
            ACCESS:  if (accLast) stateNext = PRESENT;
            PRESENT: if (xfer)    stateNext = isLast ? IDLE : SETUP;
            default:              stateNext = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            cs_addr    <= '0;
            sec        <= '0;
            burstMode  <= 1'b0;
            accCnt     <= '0;
            dout       <= '0;
            dout_sec   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state <= stateNext;

            // Request inputs are captured once; nothing is re-sampled mid-request.
            if (accept) begin
                cs_addr   <= rd_addr;
                burstMode <= rd_burst;
                sec       <= rd_burst ? 2'd0 : rd_sel;
            end

            if (state == SETUP) begin
                accCnt <= '0;
            end else if ((state == ACCESS) && !accLast) begin
                accCnt <= accCnt + 1'b1;
            end

            if (accLast) begin
                dout       <= cs_data;
                dout_sec   <= sec;
                dout_valid <= 1'b1;
                dout_last  <= isLast;
            end

            if (xfer) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                if (!isLast) begin
                    sec <= sec + 2'd1;
                end
            end
        end
    end

`ifdef CS_RB_PARITY_EN
    // Odd parity: cs_data and cs_par together must hold an odd number of ones.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            par_err <= 1'b0;
        end else if (accept) begin
            par_err <= 1'b0;
        end else if (accLast && !(^{cs_data, cs_par})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_cs_readback.sv
module tb_cpu_cs_readback;

    logic        sysclk;
    logic        sys_rst_n;
    logic        rd_req;
    logic        rd_burst;
    logic [1:0]  rd_sel;
    logic [11:0] rd_addr;
    logic        busy;
    logic [11:0] cs_addr;
    logic [3:0]  ER_n;
    logic [15:0] cs_data;
    logic [15:0] dout;
    logic [1:0]  dout_sec;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
`ifdef CS_RB_PARITY_EN
    logic        cs_par;
    logic        par_err;
`endif

    int compared   = 0;
    int mismatched = 0;
    int beats      = 0;

    logic        forceEn  = 1'b0;
    logic [15:0] forceVal = 16'h0000;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  sec;
        logic        last;
    } exp_t;

    exp_t sb[$];

    cpu_cs_readback dut (
        .sysclk     (sysclk),
        .sys_rst_n  (sys_rst_n),
        .rd_req     (rd_req),
        .rd_burst   (rd_burst),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .cs_addr    (cs_addr),
        .ER_n       (ER_n),
        .cs_data    (cs_data),
        .dout       (dout),
        .dout_sec   (dout_sec),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
`ifdef CS_RB_PARITY_EN
        ,
        .cs_par     (cs_par),
        .par_err    (par_err)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Control-store model: section content depends on section and address.
    function automatic logic [15:0] modelData(input logic [11:0] a, input int s);
        logic [15:0] base;
        base = 16'(16'h1111 * (s + 1));
        return forceEn ? forceVal : (base ^ {4'h0, a});
    endfunction

    always_comb begin
        cs_data = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            if (!ER_n[i]) cs_data = modelData(cs_addr, i);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [11:0] a, input logic b, input logic [1:0] s);
        exp_t e;
        if (b) begin
            for (int i = 0; i < 4; i++) begin
                e.data = modelData(a, i);
                e.sec  = 2'(i);
                e.last = (i == 3);
                sb.push_back(e);
            end
        end else begin
            e.data = modelData(a, int'(s));
            e.sec  = s;
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    // Leaves the DUT in SETUP, #1 after the accepting edge.
    task automatic startReq(input logic [11:0] a, input logic b, input logic [1:0] s);
        @(posedge sysclk); #1;
        rd_req = 1'b1; rd_addr = a; rd_burst = b; rd_sel = s;
        @(posedge sysclk); #1;
        rd_req = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Scoreboard and enable monitor.
    always @(negedge sysclk) begin
        if (sys_rst_n && ER_n !== 4'hF) begin
            check("erOneLow", 32'($countones(~ER_n)), 32'd1);
        end
        if (sys_rst_n && dout_valid && dout_ready) begin
            beats++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpectedBeat: observed dout %h expected no beat", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout",     32'(dout),      32'(e.data));
                check("doutSec",  32'(dout_sec),  32'(e.sec));
                check("doutLast", 32'(dout_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int n;
        logic [15:0] d0;

        sys_rst_n  = 1'b0;
        rd_req     = 1'b0;
        rd_burst   = 1'b0;
        rd_sel     = 2'd0;
        rd_addr    = 12'h000;
        dout_ready = 1'b1;
`ifdef CS_RB_PARITY_EN
        cs_par     = 1'b0;
`endif

        // Reset values
        #3;
        check("rstBusy",  32'(busy),       32'd0);
        check("rstEr",    32'(ER_n),       32'hF);
        check("rstAddr",  32'(cs_addr),    32'd0);
        check("rstDout",  32'(dout),       32'd0);
        check("rstSec",   32'(dout_sec),   32'd0);
        check("rstValid", 32'(dout_valid), 32'd0);
        check("rstLast",  32'(dout_last),  32'd0);
        #19;
        sys_rst_n = 1'b1;

        // 1: single read, section 2, cycle-accurate
        pushExp(12'h0A5, 1'b0, 2'd2);
        b0 = beats;
        startReq(12'h0A5, 1'b0, 2'd2);
        @(negedge sysclk);
        check("t1SetupBusy", 32'(busy),    32'd1);
        check("t1SetupEr",   32'(ER_n),    32'hF);
        check("t1Addr",      32'(cs_addr), 32'h0A5);
        @(negedge sysclk);
        check("t1Er1",       32'(ER_n),    32'hB);
        check("t1Valid1",    32'(dout_valid), 32'd0);
        @(negedge sysclk);
        check("t1Er2",       32'(ER_n),    32'hB);
        @(negedge sysclk);
        check("t1PresEr",    32'(ER_n),    32'hF);
        check("t1Valid",     32'(dout_valid), 32'd1);
        @(negedge sysclk);
        check("t1ValidClr",  32'(dout_valid), 32'd0);
        check("t1Idle",      32'(busy),    32'd0);
        check("t1Beats",     32'(beats - b0), 32'd1);

        // 2: burst at address 0
        pushExp(12'h000, 1'b1, 2'd0);
        b0 = beats;
        startReq(12'h000, 1'b1, 2'd0);
        waitIdle("t2Timeout");
        check("t2Beats",   32'(beats - b0), 32'd4);
        check("t2SbEmpty", 32'(sb.size()),  32'd0);

        // 3: backpressure on the first burst beat
        dout_ready = 1'b0;
        pushExp(12'h123, 1'b1, 2'd0);
        b0 = beats;
        startReq(12'h123, 1'b1, 2'd0);
        n = 0;
        while (!dout_valid && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        check("t3ValidSeen", 32'(dout_valid), 32'd1);
        d0 = dout;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            check("t3HoldDout",  32'(dout),       32'(d0));
            check("t3HoldValid", 32'(dout_valid), 32'd1);
            check("t3HoldEr",    32'(ER_n),       32'hF);
            check("t3HoldSec",   32'(dout_sec),   32'd0);
        end
        check("t3HoldData", 32'(d0), 32'(modelData(12'h123, 0)));
        @(posedge sysclk); #1;
        dout_ready = 1'b1;
        waitIdle("t3Timeout");
        check("t3Beats",   32'(beats - b0), 32'd4);
        check("t3SbEmpty", 32'(sb.size()),  32'd0);

        // 4: rd_req while busy is ignored
        pushExp(12'h050, 1'b1, 2'd0);
        b0 = beats;
        startReq(12'h050, 1'b1, 2'd0);
        @(posedge sysclk); #1;
        rd_req = 1'b1; rd_addr = 12'hFFF; rd_burst = 1'b0; rd_sel = 2'd3;
        @(posedge sysclk); #1;
        rd_req = 1'b0;
        @(negedge sysclk);
        check("t4AddrMid", 32'(cs_addr), 32'h050);
        waitIdle("t4Timeout");
        check("t4Addr",    32'(cs_addr), 32'h050);
        check("t4Beats",   32'(beats - b0), 32'd4);
        check("t4SbEmpty", 32'(sb.size()),  32'd0);

        // 5: async reset during ACCESS of section 1
        b0 = beats;
        startReq(12'h0AB, 1'b0, 2'd1);
        n = 0;
        while (ER_n !== 4'b1101 && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        check("t5ErSeen", 32'(ER_n), 32'hD);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t5RstEr",    32'(ER_n),       32'hF);
        check("t5RstBusy",  32'(busy),       32'd0);
        check("t5RstValid", 32'(dout_valid), 32'd0);
        check("t5RstAddr",  32'(cs_addr),    32'd0);
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        check("t5NoBeat", 32'(beats - b0), 32'd0);
        pushExp(12'h3C3, 1'b0, 2'd3);
        startReq(12'h3C3, 1'b0, 2'd3);
        waitIdle("t5Timeout");
        check("t5Beats", 32'(beats - b0), 32'd1);

        // Back-to-back: rd_req held high restarts straight from IDLE
        pushExp(12'h010, 1'b0, 2'd0);
        pushExp(12'h010, 1'b0, 2'd0);
        b0 = beats;
        @(posedge sysclk); #1;
        rd_req = 1'b1; rd_addr = 12'h010; rd_burst = 1'b0; rd_sel = 2'd0;
        n = 0;
        while (!dout_valid && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        check("b2bValid", 32'(dout_valid), 32'd1);
        @(negedge sysclk);
        check("b2bIdle", 32'(busy), 32'd0);
        @(negedge sysclk);
        check("b2bRestart", 32'(busy), 32'd1);
        @(posedge sysclk); #1;
        rd_req = 1'b0;
        waitIdle("b2bTimeout");
        check("b2bBeats", 32'(beats - b0), 32'd2);

`ifdef CS_RB_PARITY_EN
        // 6: parity
        forceEn  = 1'b1;
        forceVal = 16'h0001;
        cs_par   = 1'b0;
        pushExp(12'h000, 1'b0, 2'd0);
        startReq(12'h000, 1'b0, 2'd0);
        waitIdle("t6aTimeout");
        check("t6NoErr", 32'(par_err), 32'd0);
        cs_par = 1'b1;
        pushExp(12'h000, 1'b0, 2'd0);
        startReq(12'h000, 1'b0, 2'd0);
        waitIdle("t6bTimeout");
        check("t6Err", 32'(par_err), 32'd1);
        repeat (3) @(negedge sysclk);
        check("t6Sticky", 32'(par_err), 32'd1);
        cs_par = 1'b0;
        pushExp(12'h000, 1'b0, 2'd0);
        startReq(12'h000, 1'b0, 2'd0);
        check("t6Clr", 32'(par_err), 32'd0);
        waitIdle("t6cTimeout");
        check("t6StillClr", 32'(par_err), 32'd0);
        forceEn = 1'b0;
`endif

        repeat (2) @(negedge sysclk);
        check("finalSbEmpty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
